imm_gen_stage: RTL and testbench

Registered immediate-generation pipeline stage for the RISC-V core: takes a raw 32-bit instruction and its PC, decodes the instruction format from the opcode, and produces the XLEN-wide immediate, a format tag and the PC-relative target (pc + imm). It generalises the core's combinational immediate selection to RV32/RV64, adds shift-amount and CSR zero-extended immediates, and sits between fetch and decode behind a valid/ready handshake with an optional skid buffer so backpressure never costs a bubble.

---
 rtl/imm_gen_stage_pkg.sv | 36 +++
 rtl/imm_gen_stage_imm_extract.sv | 88 ++++++++
 rtl/imm_gen_stage.sv | 118 +++++++++++
 tb/tb_imm_gen_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_stage_pkg
// Constants shared between the core and the immediate-generation stage:
//   - major opcode values used for format decode
//   - fmt_e, the out_fmt encoding
//   - xlen_legal(), the datapath-width legality check
// -----------------------------------------------------------------------------
package imm_gen_stage_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
   localparam logic [6:0] OPC_STORE     = 7'b010_0011;
   localparam logic [6:0] OPC_LUI       = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
   localparam logic [6:0] OPC_JALR      = 7'b110_0111;
   localparam logic [6:0] OPC_JAL       = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b111_0011;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6,   // CSR zero-extended immediate
      FMT_SH   = 3'd7    // shift amount
   } fmt_e;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_gen_stage_imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Combinational immediate extraction: decodes the instruction format from the
// opcode and produces the XLEN-wide immediate.
//   instr  in   32    raw instruction
//   imm    out  XLEN  extended immediate (0 for FMT_NONE)
//   fmt    out  3     format tag (fmt_e)
// -----------------------------------------------------------------------------
module imm_extract
   import imm_gen_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_shift;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      // NOTE: defaults first, so every path through the case assigns both
      // outputs and no latch is inferred.
      imm = '0;
      fmt = FMT_NONE;
      case (opcode)
         OPC_OP_IMM: begin
            if (is_shift) begin
               // RV64 shamt is 6 bits; instr[25] belongs to funct7 on RV32.
               fmt = FMT_SH;
               imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            end else begin
               fmt = FMT_I;
               imm = XLEN'($signed(instr[31:20]));
            end
         end
         OPC_OP_IMM_32: begin
            // Word ops exist only on RV64; ADDIW shares the OP-IMM I layout.
            if (XLEN == 64) begin
               if (is_shift) begin
                  fmt = FMT_SH;
                  imm = XLEN'(instr[24:20]);
               end else begin
                  fmt = FMT_I;
                  imm = XLEN'($signed(instr[31:20]));
               end
            end
         end
         OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I;
            imm = XLEN'($signed(instr[31:20]));
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = XLEN'($signed({instr[31:12], 12'b0}));
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0}));
         end
         OPC_SYSTEM: begin
            // CSR*I forms carry a 5-bit zimm in the rs1 field.
            if (funct3[2]) begin
               fmt = FMT_Z;
               imm = XLEN'(instr[19:15]);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Registered immediate-generation stage between fetch and decode. Extracts
// the immediate and format of each accepted instruction, computes pc + imm,
// and presents the result one cycle later behind a valid/ready handshake.
// With SKID=1 a second entry register keeps in_ready registered while still
// sustaining one entry per cycle.
//   clock       in   1     rising-edge clock
//   reset       in   1     synchronous, active-low
//   flush       in   1     drop all held entries
//   in_valid    in   1     input entry valid
//   in_ready    out  1     stage can accept this cycle
//   in_instr    in   32    raw instruction
//   in_pc       in   XLEN  instruction PC
//   out_valid   out  1     output entry valid
//   out_ready   in   1     consumer accepts this cycle
//   out_imm     out  XLEN  extended immediate
//   out_fmt     out  3     format tag (fmt_e)
//   out_pc      out  XLEN  PC of the entry
//   out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
// -----------------------------------------------------------------------------
module imm_gen_stage
   import imm_gen_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output fmt_e            out_fmt,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_target
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
   } entry_t;

   logic [XLEN-1:0] ext_imm;
   fmt_e            ext_fmt;
   entry_t          in_entry;
   entry_t          main_q;
   entry_t          skid_q;
   logic            main_valid;
   logic            skid_valid;
   logic            accept;
   logic            drain;

   imm_extract #(.XLEN(XLEN)) u_imm_extract (
      .instr (in_instr),
      .imm   (ext_imm),
      .fmt   (ext_fmt)
   );

   // Target is formed before the register so the output is a clean flop.
   always_comb begin
      in_entry = '{imm: ext_imm, fmt: ext_fmt, pc: in_pc,
                   target: in_pc + ext_imm};
   end

   // Skid variant: skid_valid alone gates in_ready, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready = (SKID != 0) ? ~skid_valid : (~main_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign drain    = main_valid & out_ready;

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge values regardless of statement order.
      if (!reset) begin
         // NOTE: data registers are cleared too, so the outputs read
         // zero / FMT_NONE right after reset rather than stale contents.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (drain || !main_valid) begin
         // Main is free this edge: the older skid entry has priority.
         // in_ready is low whenever skid is full, so no accept is lost.
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            main_valid <= accept;
            if (accept) main_q <= in_entry;
         end
      end else if (accept && (SKID != 0)) begin
         skid_q     <= in_entry;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid  = main_valid;
   assign out_imm    = main_q.imm;
   assign out_fmt    = main_q.fmt;
   assign out_pc     = main_q.pc;
   assign out_target = main_q.target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
// Scoreboard bench: drivers push hand-computed expected entries when the DUT
// accepts; per-DUT monitors pop and compare on every output transfer.
//   dut_a: XLEN=32, SKID=1    dut_b: XLEN=64, SKID=0
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;
   import imm_gen_stage_pkg::*;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [63:0] pc;
      logic [63:0] target;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        flush;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_instr, a_in_pc, a_out_imm, a_out_pc, a_out_target;
   fmt_e        a_out_fmt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_instr;
   logic [63:0] b_in_pc, b_out_imm, b_out_pc, b_out_target;
   fmt_e        b_out_fmt;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t mon_a_e;
   exp_t mon_b_e;
   int   n_vec  = 0;
   int   n_miss = 0;

   imm_gen_stage #(.XLEN(32), .SKID(1)) u_dut_a (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .in_instr   (a_in_instr),
      .in_pc      (a_in_pc),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .out_imm    (a_out_imm),
      .out_fmt    (a_out_fmt),
      .out_pc     (a_out_pc),
      .out_target (a_out_target)
   );

   imm_gen_stage #(.XLEN(64), .SKID(0)) u_dut_b (
      .clock      (clock),
      .reset      (reset),
      .flush      (1'b0),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .in_instr   (b_in_instr),
      .in_pc      (b_in_pc),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .out_imm    (b_out_imm),
      .out_fmt    (b_out_fmt),
      .out_pc     (b_out_pc),
      .out_target (b_out_target)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Drivers hold in_valid until in_ready is seen at a falling edge, push the
   // expectation (unless the entry is meant to be discarded), and return 1
   // time unit after the accepting edge.
   task automatic drive_a(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [63:0] imm, input logic [2:0] fmt,
                          input logic [63:0] target, input bit push);
      exp_t e;
      int   n;
      a_in_valid = 1'b1;
      a_in_instr = instr;
      a_in_pc    = pc;
      n = 0;
      @(negedge clock);
      while (!a_in_ready && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (!a_in_ready) begin
         n_vec++;
         n_miss++;
         $display("FAIL a_accept_timeout: in_ready got 0 for 50 cycles, required 1");
      end else if (push) begin
         e.imm = imm; e.fmt = fmt; e.pc = 64'(pc); e.target = target;
         q_a.push_back(e);
      end
      @(posedge clock);
      #1;
      a_in_valid = 1'b0;
   endtask

   task automatic drive_b(input logic [31:0] instr, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [2:0] fmt,
                          input logic [63:0] target);
      exp_t e;
      int   n;
      b_in_valid = 1'b1;
      b_in_instr = instr;
      b_in_pc    = pc;
      n = 0;
      @(negedge clock);
      while (!b_in_ready && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (!b_in_ready) begin
         n_vec++;
         n_miss++;
         $display("FAIL b_accept_timeout: in_ready got 0 for 50 cycles, required 1");
      end else begin
         e.imm = imm; e.fmt = fmt; e.pc = pc; e.target = target;
         q_b.push_back(e);
      end
      @(posedge clock);
      #1;
      b_in_valid = 1'b0;
   endtask

   always @(negedge clock) begin
      if (a_out_valid && a_out_ready) begin
         if (q_a.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL a_unexpected: got entry pc 0x%0h, required no output", a_out_pc);
         end else begin
            mon_a_e = q_a.pop_front();
            check("a_imm",    64'(a_out_imm),    mon_a_e.imm);
            check("a_fmt",    64'(a_out_fmt),    64'(mon_a_e.fmt));
            check("a_pc",     64'(a_out_pc),     mon_a_e.pc);
            check("a_target", 64'(a_out_target), mon_a_e.target);
         end
      end
   end

   always @(negedge clock) begin
      if (b_out_valid && b_out_ready) begin
         if (q_b.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL b_unexpected: got entry pc 0x%0h, required no output", b_out_pc);
         end else begin
            mon_b_e = q_b.pop_front();
            check("b_imm",    b_out_imm,         mon_b_e.imm);
            check("b_fmt",    64'(b_out_fmt),    64'(mon_b_e.fmt));
            check("b_pc",     b_out_pc,          mon_b_e.pc);
            check("b_target", b_out_target,      mon_b_e.target);
         end
      end
   end

   initial begin
      reset = 1'b0; flush = 1'b0;
      a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("a_rst_valid",  64'(a_out_valid),  64'd0);
      check("a_rst_ready",  64'(a_in_ready),   64'd1);
      check("a_rst_imm",    64'(a_out_imm),    64'd0);
      check("a_rst_fmt",    64'(a_out_fmt),    64'd0);
      check("a_rst_pc",     64'(a_out_pc),     64'd0);
      check("a_rst_target", 64'(a_out_target), 64'd0);
      check("b_rst_valid",  64'(b_out_valid),  64'd0);
      check("b_rst_ready",  64'(b_in_ready),   64'd1);
      check("b_rst_imm",    b_out_imm,         64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // XLEN=32 directed stream, consumer always ready
      a_out_ready = 1'b1;
      drive_a(32'hFFF00093, 32'h100,  64'hFFFF_FFFF, 3'd1, 64'h0000_00FF, 1'b1); // addi -1
      drive_a(32'hFE000EE3, 32'h100,  64'hFFFF_FFFC, 3'd3, 64'h0000_00FC, 1'b1); // beq -4
      drive_a(32'h123452B7, 32'h200,  64'h1234_5000, 3'd4, 64'h1234_5200, 1'b1); // lui
      drive_a(32'hFE000EE3, 32'h0,    64'hFFFF_FFFC, 3'd3, 64'hFFFF_FFFC, 1'b1); // wrap
      drive_a(32'hFE512C23, 32'h300,  64'hFFFF_FFF8, 3'd2, 64'h0000_02F8, 1'b1); // sw -8
      drive_a(32'h001000EF, 32'h1000, 64'h0000_0800, 3'd5, 64'h0000_1800, 1'b1); // jal +2048
      drive_a(32'h00309093, 32'h40,   64'd3,         3'd7, 64'h43,        1'b1); // slli 3
      drive_a(32'h41F0D093, 32'h40,   64'd31,        3'd7, 64'h5F,        1'b1); // srai 31
      drive_a(32'h000FD073, 32'h80,   64'd31,        3'd6, 64'h9F,        1'b1); // csrrwi zimm 31
      drive_a(32'h00000073, 32'h80,   64'd0,         3'd0, 64'h80,        1'b1); // ecall
      drive_a(32'h0000007F, 32'h84,   64'd0,         3'd0, 64'h84,        1'b1); // opcode 0x7F
      drive_a(32'h0030909B, 32'h88,   64'd0,         3'd0, 64'h88,        1'b1); // slliw on RV32
      drive_a(32'hFFF12083, 32'h10,   64'hFFFF_FFFF, 3'd1, 64'h0F,        1'b1); // lw -1
      drive_a(32'h00008067, 32'h20,   64'd0,         3'd1, 64'h20,        1'b1); // jalr
      repeat (3) @(posedge clock);
      #1;

      // Skid: three back-to-back inputs against a stalled consumer
      a_out_ready = 1'b0;
      fork
         begin
            drive_a(32'h123452B7, 32'h400, 64'h1234_5000, 3'd4, 64'h1234_5400, 1'b1);
            drive_a(32'hFFF00093, 32'h404, 64'hFFFF_FFFF, 3'd1, 64'h0000_0403, 1'b1);
            drive_a(32'h001000EF, 32'h408, 64'h0000_0800, 3'd5, 64'h0000_0C08, 1'b1);
         end
         begin
            repeat (2) @(posedge clock);
            @(negedge clock);
            check("a_skid_out_valid", 64'(a_out_valid), 64'd1);
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clock);
               check("a_skid_in_ready", 64'(a_in_ready), 64'd0);
               check("a_skid_hold_imm", 64'(a_out_imm),  64'h1234_5000);
            end
            @(posedge clock);
            #1;
            a_out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clock);
      #1;
      check("a_skid_drained", 64'(q_a.size()), 64'd0);

      // Flush with main and skid full and a valid input pending
      a_out_ready = 1'b0;
      drive_a(32'hFFF00093, 32'h500, 64'd0, 3'd0, 64'd0, 1'b0);
      drive_a(32'hFE000EE3, 32'h504, 64'd0, 3'd0, 64'd0, 1'b0);
      a_in_valid = 1'b1; a_in_instr = 32'h123452B7; a_in_pc = 32'h508;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0; a_in_valid = 1'b0;
      @(negedge clock);
      check("a_flush_out_valid", 64'(a_out_valid), 64'd0);
      check("a_flush_in_ready",  64'(a_in_ready),  64'd1);
      // Flush on an empty stage discards the same-cycle accept
      @(posedge clock);
      #1;
      a_in_valid = 1'b1; a_in_instr = 32'h00309093; a_in_pc = 32'h50C;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0; a_in_valid = 1'b0;
      @(negedge clock);
      check("a_flush_accept_dropped", 64'(a_out_valid), 64'd0);
      a_out_ready = 1'b1;
      repeat (3) @(negedge clock);
      @(posedge clock);
      #1;

      // Reset mid-stream with an entry held and an input pending
      a_out_ready = 1'b0;
      drive_a(32'hFE512C23, 32'h600, 64'd0, 3'd0, 64'd0, 1'b0);
      a_in_valid = 1'b1; a_in_instr = 32'h001000EF; a_in_pc = 32'h604;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1; a_in_valid = 1'b0;
      @(negedge clock);
      check("a_mid_rst_valid",  64'(a_out_valid),  64'd0);
      check("a_mid_rst_fmt",    64'(a_out_fmt),    64'd0);
      check("a_mid_rst_imm",    64'(a_out_imm),    64'd0);
      check("a_mid_rst_target", 64'(a_out_target), 64'd0);
      check("a_mid_rst_ready",  64'(a_in_ready),   64'd1);
      @(posedge clock);
      #1;
      a_out_ready = 1'b1;
      drive_a(32'hFFF00093, 32'h700, 64'hFFFF_FFFF, 3'd1, 64'h0000_06FF, 1'b1);
      check("a_latency_valid", 64'(a_out_valid), 64'd1);
      repeat (3) @(posedge clock);
      #1;

      // XLEN=64 directed stream
      b_out_ready = 1'b1;
      drive_b(32'h800002B7, 64'h1000, 64'hFFFF_FFFF_8000_0000, 3'd4, 64'hFFFF_FFFF_8000_1000); // lui
      drive_b(32'h03F09093, 64'h2000, 64'd63, 3'd7, 64'h203F);                                 // slli 63
      drive_b(32'h4210D093, 64'h10,   64'd33, 3'd7, 64'h31);                                   // srai 33
      drive_b(32'h000FD073, 64'h3000, 64'd31, 3'd6, 64'h301F);                                 // csrrwi
      drive_b(32'h0000007F, 64'h3004, 64'd0,  3'd0, 64'h3004);                                 // none
      drive_b(32'h01F0909B, 64'h3008, 64'd31, 3'd7, 64'h3027);                                 // slliw 31
      drive_b(32'hFFF00093, 64'h100,  64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFF);                 // addi -1
      drive_b(32'hFE000EE3, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC); // wrap
      repeat (2) @(posedge clock);
      #1;

      // XLEN=64 single register: in_ready follows out_ready combinationally
      b_out_ready = 1'b0;
      drive_b(32'hFFF00093, 64'h500, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'h4FF);
      check("b_stall_in_ready", 64'(b_in_ready), 64'd0);
      b_out_ready = 1'b1;
      #1;
      check("b_pass_in_ready", 64'(b_in_ready), 64'd1);
      repeat (3) @(posedge clock);
      #1;

      check("a_queue_empty", 64'(q_a.size()), 64'd0);
      check("b_queue_empty", 64'(q_b.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
